// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB sequencer: FSM state encoding, default widths
// and the default page mask.
package tlb_pkg;

  localparam int DEF_VA_W       = 64;
  localparam int DEF_PCID_W     = 12;
  localparam int DEF_PAGE_SHIFT = 12;
  localparam int CNT_W          = 32;

  localparam logic [DEF_VA_W-1:0] DEF_PAGE_MASK = {DEF_VA_W{1'b1}} << DEF_PAGE_SHIFT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_WALK_REQ,
    ST_WALK_WAIT,
    ST_FILL,
    ST_RESP
  } tlb_state_e;

endpackage

// File: rtl/tlb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at last_grant+1 and wraps,
// producing a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter  int NREQ  = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  int cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(last_grant) + 1 + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!any_grant && (i == cand) && req[i]) begin
          any_grant = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/tlb_ctrl.sv
// Sequencer/arbiter in front of the shared TLB: grants one requester at a time,
// runs lookup, page-table walk and fill, answers, serialises flushes and counts.
module tlb_ctrl
  import tlb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int VA_W       = DEF_VA_W,
  parameter int PCID_W     = DEF_PCID_W,
  parameter int PAGE_SHIFT = DEF_PAGE_SHIFT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*VA_W-1:0]   req_va,
  input  logic [NREQ*PCID_W-1:0] req_pcid,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        resp_valid,
  output logic [VA_W-1:0]        resp_pa,
  output logic                   resp_fault,
  output logic                   tlb_lookup,
  output logic [VA_W-1:0]        tlb_va,
  output logic [PCID_W-1:0]      tlb_pcid,
  input  logic                   tlb_hit,
  input  logic                   tlb_miss,
  input  logic [VA_W-1:0]        tlb_pa,
  output logic                   tlb_fill_en,
  output logic [VA_W-1:0]        tlb_fill_pa,
  output logic                   tlb_flush,
  output logic                   walk_req_valid,
  input  logic                   walk_req_ready,
  output logic [VA_W-1:0]        walk_va,
  output logic [PCID_W-1:0]      walk_pcid,
  input  logic                   walk_resp_valid,
  input  logic [VA_W-1:0]        walk_resp_pa,
  input  logic                   walk_resp_fault,
  input  logic                   flush_req,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       miss_cnt
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [VA_W-1:0] PAGE_MASK = {VA_W{1'b1}} << PAGE_SHIFT;

  function automatic logic [VA_W-1:0] page_base(input logic [VA_W-1:0] a);
    return a & PAGE_MASK;
  endfunction

  function automatic logic [VA_W-1:0] join_pa(input logic [VA_W-1:0] frame,
                                              input logic [VA_W-1:0] va);
    return (frame & PAGE_MASK) | (va & ~PAGE_MASK);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  tlb_state_e        state, next_state;
  logic              flush_pending;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  idx_r;
  logic [VA_W-1:0]   va_r;
  logic [PCID_W-1:0] pcid_r;
  logic [VA_W-1:0]   frame_r;
  logic              fault_r;

  logic [NREQ-1:0]   gnt_vec;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              grant_en;
  logic              flush_issue;
  logic [VA_W-1:0]   va_sel;
  logic [PCID_W-1:0] pcid_sel;

  // Any miss/neither combination takes the walk path, so the miss strobe is informational.
  logic unused_tlb_miss;
  assign unused_tlb_miss = tlb_miss;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (gnt_vec),
    .grant_idx  (gnt_idx),
    .any_grant  (gnt_any)
  );

  always_comb begin
    va_sel   = '0;
    pcid_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vec[i]) begin
        va_sel   = req_va[i*VA_W +: VA_W];
        pcid_sel = req_pcid[i*PCID_W +: PCID_W];
      end
    end
  end

  always_comb begin
    next_state     = state;
    grant_en       = 1'b0;
    flush_issue    = 1'b0;
    req_ready      = '0;
    resp_valid     = '0;
    resp_pa        = '0;
    resp_fault     = 1'b0;
    tlb_lookup     = 1'b0;
    tlb_va         = '0;
    tlb_pcid       = '0;
    tlb_fill_en    = 1'b0;
    tlb_fill_pa    = '0;
    tlb_flush      = 1'b0;
    walk_req_valid = 1'b0;
    walk_va        = '0;
    walk_pcid      = '0;
    unique case (state)
      ST_IDLE: begin
        // A pending flush always wins the IDLE slot over a new grant.
        if (flush_pending) begin
          tlb_flush   = 1'b1;
          flush_issue = 1'b1;
        end else if (gnt_any) begin
          req_ready  = gnt_vec;
          grant_en   = 1'b1;
          next_state = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        tlb_lookup = 1'b1;
        tlb_va     = va_r;
        tlb_pcid   = pcid_r;
        next_state = ST_CHECK;
      end
      ST_CHECK: begin
        next_state = tlb_hit ? ST_RESP : ST_WALK_REQ;
      end
      ST_WALK_REQ: begin
        walk_req_valid = 1'b1;
        walk_va        = va_r;
        walk_pcid      = pcid_r;
        if (walk_req_ready) next_state = ST_WALK_WAIT;
      end
      ST_WALK_WAIT: begin
        if (walk_resp_valid) next_state = walk_resp_fault ? ST_RESP : ST_FILL;
      end
      ST_FILL: begin
        tlb_fill_en = 1'b1;
        tlb_va      = page_base(va_r);
        tlb_pcid    = pcid_r;
        tlb_fill_pa = page_base(frame_r);
        next_state  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = {{(NREQ-1){1'b0}}, 1'b1} << idx_r;
        resp_pa    = fault_r ? '0 : join_pa(frame_r, va_r);
        resp_fault = fault_r;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Control state: FSM, flush request, arbitration pointer, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      flush_pending <= 1'b0;
      last_grant    <= IDX_W'(NREQ - 1);
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      state         <= next_state;
      flush_pending <= (flush_pending & ~flush_issue) | flush_req;
      if (grant_en) last_grant <= gnt_idx;
      if (state == ST_CHECK) begin
        if (tlb_hit) hit_cnt  <= sat_inc(hit_cnt);
        else         miss_cnt <= sat_inc(miss_cnt);
      end
    end
  end

  // Translation context: only observed through state-gated outputs, so no reset
  always_ff @(posedge clk) begin
    if (grant_en) begin
      idx_r   <= gnt_idx;
      va_r    <= va_sel;
      pcid_r  <= pcid_sel;
      fault_r <= 1'b0;
    end
    if (state == ST_CHECK && tlb_hit) frame_r <= tlb_pa;
    if (state == ST_WALK_WAIT && walk_resp_valid) begin
      frame_r <= walk_resp_pa;
      fault_r <= walk_resp_fault;
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Scenario bench for tlb_ctrl with behavioural TLB and page-walker models and a
// response scoreboard filled at grant time.
module tb_tlb_ctrl;

  localparam int NREQ   = 2;
  localparam int VA_W   = 64;
  localparam int PCID_W = 12;
  localparam logic [63:0] PMASK = 64'hFFFF_FFFF_FFFF_F000;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*VA_W-1:0]   req_va = '0;
  logic [NREQ*PCID_W-1:0] req_pcid = '0;
  logic [NREQ-1:0]        req_ready, resp_valid;
  logic [VA_W-1:0]        resp_pa;
  logic                   resp_fault, tlb_lookup;
  logic [VA_W-1:0]        tlb_va;
  logic [PCID_W-1:0]      tlb_pcid;
  logic                   tlb_hit = 1'b0, tlb_miss = 1'b0;
  logic [VA_W-1:0]        tlb_pa = '0;
  logic                   tlb_fill_en;
  logic [VA_W-1:0]        tlb_fill_pa;
  logic                   tlb_flush, walk_req_valid;
  logic                   walk_req_ready = 1'b1;
  logic [VA_W-1:0]        walk_va;
  logic [PCID_W-1:0]      walk_pcid;
  logic                   walk_resp_valid = 1'b0;
  logic [VA_W-1:0]        walk_resp_pa = '0;
  logic                   walk_resp_fault = 1'b0;
  logic                   flush_req = 1'b0;
  logic [31:0]            hit_cnt, miss_cnt;

  tlb_ctrl #(.NREQ(NREQ), .VA_W(VA_W), .PCID_W(PCID_W), .PAGE_SHIFT(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_va(req_va), .req_pcid(req_pcid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_pa(resp_pa), .resp_fault(resp_fault),
    .tlb_lookup(tlb_lookup), .tlb_va(tlb_va), .tlb_pcid(tlb_pcid),
    .tlb_hit(tlb_hit), .tlb_miss(tlb_miss), .tlb_pa(tlb_pa),
    .tlb_fill_en(tlb_fill_en), .tlb_fill_pa(tlb_fill_pa), .tlb_flush(tlb_flush),
    .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready),
    .walk_va(walk_va), .walk_pcid(walk_pcid),
    .walk_resp_valid(walk_resp_valid), .walk_resp_pa(walk_resp_pa),
    .walk_resp_fault(walk_resp_fault), .flush_req(flush_req),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [63:0] pa;
    logic        fault;
    int          cyc;
  } resp_t;

  int n_checks = 0, n_errors = 0;
  int cycle = 0;

  // Environment model state
  int          budget [NREQ];
  logic [63:0] rva    [NREQ];
  logic [11:0] rpcid  [NREQ];
  int          tlb_mode = 0;   // 0 hit, 1 miss, 2 both strobes, 3 neither
  logic [63:0] mode_pa = '0;
  logic [63:0] walk_pa_m = '0;
  logic        walk_fault_m = 1'b0;
  int          walk_lat = 5;
  int          walk_cd = 0;
  bit          lookup_seen = 0;
  bit          flush_in_walk = 0;
  bit          grant_flush_overlap = 0;
  int          exp_hits = 0, exp_misses = 0;

  resp_t       exp_q[$], got_q[$];
  int          grant_idx_q[$], grant_cyc_q[$], flush_cyc_q[$];
  logic [63:0] fill_va_q[$], fill_pa_q[$];

  task automatic clear_logs();
    grant_idx_q.delete(); grant_cyc_q.delete(); flush_cyc_q.delete();
    fill_va_q.delete(); fill_pa_q.delete(); got_q.delete(); exp_q.delete();
    grant_flush_overlap = 0;
  endtask

  // One clock: observe DUT at the falling edge, then drive models after the rising edge.
  task automatic tick();
    logic [63:0] pa;
    logic        f;
    bit          hit_pred;
    @(negedge clk);
    lookup_seen = tlb_lookup;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        grant_idx_q.push_back(i);
        grant_cyc_q.push_back(cycle);
        budget[i]--;
        hit_pred = (tlb_mode == 0 || tlb_mode == 2);
        if (hit_pred) begin
          pa = (mode_pa & PMASK) | (rva[i] & ~PMASK); f = 1'b0; exp_hits++;
        end else begin
          exp_misses++;
          if (walk_fault_m) begin pa = '0; f = 1'b1; end
          else begin pa = (walk_pa_m & PMASK) | (rva[i] & ~PMASK); f = 1'b0; end
        end
        exp_q.push_back('{i, pa, f, cycle});
      end
    end
    if (walk_req_valid && walk_req_ready) walk_cd = walk_lat;
    if (tlb_fill_en) begin fill_va_q.push_back(tlb_va); fill_pa_q.push_back(tlb_fill_pa); end
    if (tlb_flush) begin
      flush_cyc_q.push_back(cycle);
      if (req_ready != '0) grant_flush_overlap = 1;
    end
    for (int i = 0; i < NREQ; i++)
      if (resp_valid[i]) got_q.push_back('{i, resp_pa, resp_fault, cycle});
    @(posedge clk);
    cycle++;
    #1;
    tlb_hit  = lookup_seen && (tlb_mode == 0 || tlb_mode == 2);
    tlb_miss = lookup_seen && (tlb_mode == 1 || tlb_mode == 2);
    tlb_pa   = lookup_seen ? mode_pa : '0;
    walk_resp_valid = 1'b0; walk_resp_pa = '0; walk_resp_fault = 1'b0;
    flush_req = 1'b0;
    if (walk_cd > 0) begin
      walk_cd--;
      if (walk_cd == 0) begin
        walk_resp_valid = 1'b1; walk_resp_pa = walk_pa_m; walk_resp_fault = walk_fault_m;
      end
      if (flush_in_walk && walk_cd == 2) begin flush_req = 1'b1; flush_in_walk = 0; end
    end
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (budget[i] > 0);
      req_va[i*VA_W +: VA_W] = rva[i];
      req_pcid[i*PCID_W +: PCID_W] = rpcid[i];
    end
  endtask

  task automatic start_req(input int i, input logic [63:0] va, input logic [11:0] pcid, input int n);
    budget[i] = n; rva[i] = va; rpcid[i] = pcid;
    req_valid[i] = 1'b1;
    req_va[i*VA_W +: VA_W] = va;
    req_pcid[i*PCID_W +: PCID_W] = pcid;
  endtask

  task automatic wait_resp(input int n, input int limit, output bit ok);
    int k = 0;
    while (got_q.size() < n && k < limit) begin tick(); k++; end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({req_ready, resp_valid, resp_fault, tlb_lookup, tlb_fill_en, tlb_flush, walk_req_valid} !== '0) begin
      n_errors++; $display("FAIL reset_strobes: got %b, expected all 0",
        {req_ready, resp_valid, resp_fault, tlb_lookup, tlb_fill_en, tlb_flush, walk_req_valid});
    end
    n_checks++;
    if ((resp_pa | tlb_va | tlb_fill_pa | walk_va) !== '0 || (tlb_pcid | walk_pcid) !== '0) begin
      n_errors++; $display("FAIL reset_data: resp_pa=%h tlb_va=%h fill_pa=%h walk_va=%h, expected 0",
        resp_pa, tlb_va, tlb_fill_pa, walk_va);
    end
    n_checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_errors++; $display("FAIL reset_counters: hit=%0d miss=%0d, expected 0 0", hit_cnt, miss_cnt);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_hit();
    bit ok; resp_t g, e;
    clear_logs();
    tlb_mode = 0; mode_pa = 64'h5000;
    start_req(0, 64'h1234, 12'h0, 1);
    wait_resp(1, 20, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL hit_timeout: got 0 responses, expected 1"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g.idx !== 0 || g.pa !== 64'h5234 || g.fault !== 1'b0 || g.pa !== e.pa) begin
        n_errors++; $display("FAIL hit_resp: got idx=%0d pa=%h fault=%0d, expected idx=0 pa=%h fault=0",
          g.idx, g.pa, g.fault, e.pa);
      end
      n_checks++;
      if (g.cyc - e.cyc !== 3) begin
        n_errors++; $display("FAIL hit_latency: got %0d cycles, expected 3", g.cyc - e.cyc);
      end
    end
    n_checks++;
    if (hit_cnt !== 32'd1) begin n_errors++; $display("FAIL hit_cnt: got %0d, expected 1", hit_cnt); end
  endtask

  task automatic test_miss_fill();
    bit ok; resp_t g, e;
    clear_logs();
    tlb_mode = 1; walk_pa_m = 64'hA000; walk_fault_m = 1'b0; walk_lat = 5;
    start_req(1, 64'hFFFF_FFFF_FFFF_FFF1, 12'h5, 1);
    wait_resp(1, 40, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL miss_timeout: got 0 responses, expected 1"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g.idx !== 1 || g.pa !== 64'hAFF1 || g.fault !== 1'b0 || g.pa !== e.pa) begin
        n_errors++; $display("FAIL miss_resp: got idx=%0d pa=%h fault=%0d, expected idx=1 pa=%h fault=0",
          g.idx, g.pa, g.fault, e.pa);
      end
    end
    n_checks++;
    if (fill_va_q.size() != 1) begin
      n_errors++; $display("FAIL miss_fill_count: got %0d fills, expected 1", fill_va_q.size());
    end else if (fill_va_q[0] !== 64'hFFFF_FFFF_FFFF_F000 || fill_pa_q[0] !== 64'hA000) begin
      n_errors++; $display("FAIL miss_fill_key: got va=%h pa=%h, expected va=FFFFFFFFFFFFF000 pa=A000",
        fill_va_q[0], fill_pa_q[0]);
    end
    n_checks++;
    if (miss_cnt !== 32'd1) begin n_errors++; $display("FAIL miss_cnt: got %0d, expected 1", miss_cnt); end
  endtask

  task automatic test_arbitration();
    bit ok; resp_t g, e;
    int order[4] = '{0, 1, 0, 1};
    clear_logs();
    tlb_mode = 0; mode_pa = 64'h0000_0000_8000_0000;
    start_req(0, 64'h1000_0111, 12'h1, 2);
    start_req(1, 64'h2000_0222, 12'h2, 2);
    wait_resp(4, 40, ok);
    n_checks++;
    if (!ok || grant_idx_q.size() != 4) begin
      n_errors++; $display("FAIL arb_timeout: got %0d responses, expected 4", got_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        n_checks++;
        if (grant_idx_q[k] !== order[k] || g.idx !== e.idx || g.pa !== e.pa) begin
          n_errors++; $display("FAIL arb_grant%0d: got grant=%0d resp idx=%0d pa=%h, expected %0d pa=%h",
            k, grant_idx_q[k], g.idx, g.pa, order[k], e.pa);
        end
        if (k > 0) begin
          n_checks++;
          if (grant_cyc_q[k] - grant_cyc_q[k-1] !== 4) begin
            n_errors++; $display("FAIL arb_spacing: got %0d cycles, expected 4",
              grant_cyc_q[k] - grant_cyc_q[k-1]);
          end
        end
      end
    end
    n_checks++;
    if (hit_cnt !== exp_hits) begin n_errors++; $display("FAIL arb_hit_cnt: got %0d, expected %0d", hit_cnt, exp_hits); end
  endtask

  task automatic test_fault();
    bit ok; resp_t g;
    clear_logs();
    tlb_mode = 1; walk_pa_m = 64'hDEAD_B000; walk_fault_m = 1'b1; walk_lat = 3;
    start_req(0, 64'h4444_5678, 12'h7, 1);
    wait_resp(1, 40, ok);
    tick();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL fault_timeout: got 0 responses, expected 1"); end
    else begin
      g = got_q.pop_front(); void'(exp_q.pop_front());
      n_checks++;
      if (g.idx !== 0 || g.pa !== 64'h0 || g.fault !== 1'b1) begin
        n_errors++; $display("FAIL fault_resp: got idx=%0d pa=%h fault=%0d, expected idx=0 pa=0 fault=1",
          g.idx, g.pa, g.fault);
      end
    end
    n_checks++;
    if (fill_va_q.size() != 0) begin n_errors++; $display("FAIL fault_fill: got %0d fills, expected 0", fill_va_q.size()); end
    n_checks++;
    if (miss_cnt !== exp_misses) begin n_errors++; $display("FAIL fault_miss_cnt: got %0d, expected %0d", miss_cnt, exp_misses); end
    walk_fault_m = 1'b0;
  endtask

  task automatic test_check_corner();
    bit ok; resp_t g, e;
    clear_logs();
    tlb_mode = 2; mode_pa = 64'h0003_3000;
    start_req(1, 64'h0000_9ABC, 12'h9, 1);
    wait_resp(1, 20, ok);
    tlb_mode = 3; walk_pa_m = 64'h0007_7000; walk_lat = 2;
    start_req(1, 64'h0000_0DEF, 12'h9, 1);
    wait_resp(2, 40, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL corner_timeout: got %0d responses, expected 2", got_q.size()); end
    else begin
      for (int k = 0; k < 2; k++) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        n_checks++;
        if (g.pa !== e.pa || g.fault !== e.fault) begin
          n_errors++; $display("FAIL corner_resp%0d: got pa=%h fault=%0d, expected pa=%h fault=%0d",
            k, g.pa, g.fault, e.pa, e.fault);
        end
      end
    end
    n_checks++;
    if (hit_cnt !== exp_hits || miss_cnt !== exp_misses) begin
      n_errors++; $display("FAIL corner_cnt: got hit=%0d miss=%0d, expected hit=%0d miss=%0d",
        hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
  endtask

  task automatic test_flush_with_req();
    bit ok; int req_cyc;
    clear_logs();
    tlb_mode = 0; mode_pa = 64'h0001_2000;
    start_req(0, 64'h0000_0345, 12'h1, 1);
    flush_req = 1'b1;
    req_cyc = cycle;
    wait_resp(1, 20, ok);
    tick(); tick();
    n_checks++;
    if (!ok || grant_cyc_q.size() < 1 || grant_cyc_q[0] != req_cyc) begin
      n_errors++; $display("FAIL flushreq_grant: got grant count %0d, expected grant at cycle %0d",
        grant_cyc_q.size(), req_cyc);
    end
    n_checks++;
    if (!ok || flush_cyc_q.size() != 1 || flush_cyc_q[0] != got_q[0].cyc + 1) begin
      n_errors++; $display("FAIL flushreq_flush: got %0d flushes, expected 1 right after the response",
        flush_cyc_q.size());
    end
  endtask

  task automatic test_flush_during_walk();
    bit ok;
    clear_logs();
    tlb_mode = 1; walk_pa_m = 64'h0055_5000; walk_lat = 6;
    flush_in_walk = 1;
    start_req(0, 64'h0000_6789, 12'h2, 2);
    wait_resp(2, 80, ok);
    n_checks++;
    if (!ok || flush_cyc_q.size() != 1 || grant_cyc_q.size() != 2) begin
      n_errors++; $display("FAIL walkflush_count: got %0d flushes %0d grants, expected 1 and 2",
        flush_cyc_q.size(), grant_cyc_q.size());
    end else begin
      n_checks++;
      if (flush_cyc_q[0] != got_q[0].cyc + 1) begin
        n_errors++; $display("FAIL walkflush_timing: got flush at %0d, expected %0d", flush_cyc_q[0], got_q[0].cyc + 1);
      end
      n_checks++;
      if (grant_cyc_q[1] != flush_cyc_q[0] + 1) begin
        n_errors++; $display("FAIL walkflush_regrant: got grant at %0d, expected %0d", grant_cyc_q[1], flush_cyc_q[0] + 1);
      end
      n_checks++;
      if (got_q[1].pa !== exp_q[1].pa) begin
        n_errors++; $display("FAIL walkflush_resp: got pa=%h, expected %h", got_q[1].pa, exp_q[1].pa);
      end
    end
    n_checks++;
    if (grant_flush_overlap) begin n_errors++; $display("FAIL walkflush_overlap: got grant with flush, expected none"); end
  endtask

  task automatic test_reset_mid_walk();
    bit ok; int k = 0; resp_t g;
    clear_logs();
    tlb_mode = 1; walk_pa_m = 64'h0099_9000; walk_lat = 8;
    start_req(0, 64'hBEEF_0123, 12'h3, 1);
    while (walk_cd != 4 && k < 40) begin tick(); k++; end
    n_checks++;
    if (walk_cd != 4) begin n_errors++; $display("FAIL rstwalk_reach: got walk_cd=%0d, expected 4", walk_cd); end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({req_ready, resp_valid, resp_fault, tlb_lookup, tlb_fill_en, tlb_flush, walk_req_valid} !== '0
        || (resp_pa | tlb_va | tlb_fill_pa | walk_va) !== '0) begin
      n_errors++; $display("FAIL rstwalk_outputs: got strobes=%b resp_pa=%h, expected all 0",
        {req_ready, resp_valid, resp_fault, tlb_lookup, tlb_fill_en, tlb_flush, walk_req_valid}, resp_pa);
    end
    n_checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_errors++; $display("FAIL rstwalk_cnt: got hit=%0d miss=%0d, expected 0 0", hit_cnt, miss_cnt);
    end
    exp_q.delete(); exp_hits = 0; exp_misses = 0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) tick();
    n_checks++;
    if (got_q.size() != 0 || fill_va_q.size() != 0 || miss_cnt !== 32'd0) begin
      n_errors++; $display("FAIL rstwalk_late: got %0d responses %0d fills miss=%0d, expected 0 0 0",
        got_q.size(), fill_va_q.size(), miss_cnt);
    end
    tlb_mode = 0; mode_pa = 64'h3000;
    start_req(0, 64'h7777, 12'h0, 1);
    wait_resp(1, 20, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL rstwalk_after: got 0 responses, expected 1"); end
    else begin
      g = got_q.pop_front();
      if (g.pa !== 64'h3777 || g.cyc - exp_q[0].cyc !== 3 || hit_cnt !== 32'd1) begin
        n_errors++; $display("FAIL rstwalk_after_resp: got pa=%h lat=%0d hit=%0d, expected 3777 3 1",
          g.pa, g.cyc - exp_q[0].cyc, hit_cnt);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin budget[i] = 0; rva[i] = '0; rpcid[i] = '0; end
    test_reset();
    test_single_hit();
    test_miss_fill();
    test_arbitration();
    test_fault();
    test_check_corner();
    test_flush_with_req();
    test_flush_during_walk();
    test_reset_mid_walk();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tlb_ctrl.md
# tlb_ctrl

Sequencer and arbiter in front of the set-associative TLB `cache`. It shares one TLB between NREQ translation requesters using round-robin arbitration, and issues the lookup. On a miss it requests a page-table walk, writes the returned translation into the TLB, then answers the requester. It also serialises TLB flushes and keeps hit/miss performance counters.

## Interface
- NREQ, 2, number of requesters (2..4)
- VA_W, 64, virtual/physical address width
- PCID_W, 12, process-context ID width
- PAGE_SHIFT, 12, page-offset bits
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  translation request per requester
- req_va  in  NREQ*VA_W  packed VAs; requester i at [i*VA_W +: VA_W]
- req_pcid  in  NREQ*PCID_W  packed PCIDs
- req_ready  out  NREQ  one-hot grant pulse; handshake when valid&ready
- resp_valid  out  NREQ  one-hot single-cycle response pulse, no backpressure
- resp_pa  out  VA_W  translated address, valid with resp_valid
- resp_fault  out  1  walk reported fault, valid with resp_valid
- tlb_lookup  out  1  lookup strobe to TLB
- tlb_va / tlb_pcid  out  VA_W / PCID_W  lookup or fill key
- tlb_hit / tlb_miss  in  1 / 1  TLB result, one cycle after tlb_lookup
- tlb_pa  in  VA_W  TLB output address, valid with tlb_hit
- tlb_fill_en  out  1  single-cycle write strobe; tlb_fill_pa out VA_W fill frame
- tlb_flush  out  1  single-cycle flush-all strobe
- walk_req_valid  out  1 ; walk_req_ready in 1 ; walk_va/walk_pcid out, held while valid
- walk_resp_valid  in  1 ; walk_resp_pa in VA_W ; walk_resp_fault in 1
- flush_req  in  1  flush request pulse
- hit_cnt / miss_cnt  out  32 / 32  saturating counters

## Operation
- FSM states: IDLE, LOOKUP, CHECK, WALK_REQ, WALK_WAIT, FILL, RESP.
- IDLE:
  - if flush_pending, assert tlb_flush for one cycle, clear it, stay IDLE; no grant that cycle.
  - else if any req_valid, grant the winner (req_ready=1 that cycle), latch va/pcid/index, go to LOOKUP.
- Arbitration: rotating priority starting at last_grant+1 mod NREQ. last_grant resets to NREQ-1, so requester 0 wins first.
- LOOKUP: tlb_lookup=1 with latched key → CHECK.
- CHECK: tlb_hit → RESP with pa=tlb_pa and hit_cnt++. Otherwise (miss, or neither asserted) → WALK_REQ with miss_cnt++. Both asserted counts as a hit.
- WALK_REQ: walk_req_valid=1 until walk_req_ready → WALK_WAIT.
- WALK_WAIT: on walk_resp_valid, a fault goes to RESP with resp_fault=1, pa=0 and no fill. Otherwise go to FILL.
- FILL: tlb_fill_en=1 for one cycle. Key is va with its low PAGE_SHIFT bits zeroed; tlb_fill_pa is walk_resp_pa with its low PAGE_SHIFT bits zeroed. → RESP.
- RESP: resp_valid[latched index]=1 for one cycle. resp_pa = {frame[VA_W-1:PAGE_SHIFT], va[PAGE_SHIFT-1:0]} for both hit and fill paths. → IDLE.
- flush_req in any state sets flush_pending. A flush is never issued mid-translation; it is issued on the next IDLE cycle, ahead of any grant.
- walk_resp_valid outside WALK_WAIT is ignored; tlb_hit/tlb_miss outside CHECK are ignored.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset (async assert, sync release) forces:
  - state=IDLE, flush_pending=0, counters=0, last_grant=NREQ-1.
  - All strobes/valids/ready 0; all address/data outputs 0.
  - Reset mid-walk abandons the translation; no response is issued.
- Hit latency: grant at cycle 0, lookup at 1, check at 2, resp_valid at 3. Back-to-back hits give one translation per 4 cycles.
- Miss latency: 6 cycles + walk_req wait + walk latency (grant 0, lookup 1, check 2, walk_req ≥3, fill, resp).
- Simultaneous flush_req and req_valid in IDLE with no flush pending: grant proceeds and the flush is deferred to the next IDLE.
- Simultaneous request from all requesters: each is served once per NREQ translations.

## Structure
- Shared package tlb_pkg:
  - state enum;
  - default widths VA_W, PCID_W, PAGE_SHIFT;
  - page-mask constant.
- Sub-module rr_arbiter: NREQ request vector + last_grant → one-hot grant and encoded index, purely combinational. Instantiated once.
- Counters and FSM live in tlb_ctrl.

## Test plan
- Single hit: req0 va=64'h1234 pcid=0, TLB answers hit with tlb_pa=64'h5000 at cycle 2 → resp_valid[0] at cycle 3, resp_pa=64'h5234, resp_fault=0, hit_cnt=1.
- Miss + fill: req1 va=64'hFFFF_FFFF_FFFF_FFF1, TLB miss, walker ready immediately and returns pa 64'hA000 after 5 cycles → tlb_fill_en key va=...F000 pa=64'hA000, then resp_valid[1], resp_pa=64'hAFF1, miss_cnt=1.
- Fault: walker returns fault=1 → no tlb_fill_en, resp_fault=1, resp_pa=0.
- Arbitration: req0 and req1 held valid for 4 translations, all hits → grant order 0,1,0,1.
- Flush during walk: flush_req pulsed in WALK_WAIT → tlb_flush one cycle after RESP, before the next grant; the pending req0 is granted the cycle after.
- Reset mid-walk: rst_n low in WALK_WAIT, then the walker later returns a response → all outputs 0 immediately, no resp_valid, counters 0, late walk_resp ignored.
